// File: rtl/decode_stage_pkg.sv
// Shared types for the registered RV decode stage: opcodes, decoded-bundle layout
// and the funct3/funct7 to ALU-function mapping used by the decoder.
package decode_stage_pkg;

    // Build-wide datapath width; immediate and pc fields in the bundle use it.
    localparam int PKG_XLEN = 32;

    typedef logic [PKG_XLEN-1:0] t_xword;

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37
    } t_opcode;

    typedef enum logic [2:0] {
        OK_ILLEGAL = 3'd0,
        OK_OP_IMM  = 3'd1,
        OK_OP      = 3'd2,
        OK_LUI     = 3'd3,
        OK_AUIPC   = 3'd4
    } t_op_kind;

    typedef enum logic [3:0] {
        FK_ADD  = 4'd0,
        FK_SUB  = 4'd1,
        FK_SLL  = 4'd2,
        FK_SLT  = 4'd3,
        FK_SLTU = 4'd4,
        FK_XOR  = 4'd5,
        FK_SRL  = 4'd6,
        FK_SRA  = 4'd7,
        FK_OR   = 4'd8,
        FK_AND  = 4'd9
    } t_func_kind;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        t_op_kind   kind;
        t_func_kind func;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        t_xword     imm;
        t_xword     pc;
        logic       illegal;
    } t_decoded_instr;

    // alt selects SUB on funct3=000 and SRA on funct3=101; ignored elsewhere.
    function automatic t_func_kind alu_func(input logic [2:0] funct3, input logic alt);
        t_func_kind f;
        case (funct3)
            3'b000:  f = alt ? FK_SUB : FK_ADD;
            3'b001:  f = FK_SLL;
            3'b010:  f = FK_SLT;
            3'b011:  f = FK_SLTU;
            3'b100:  f = FK_XOR;
            3'b101:  f = alt ? FK_SRA : FK_SRL;
            3'b110:  f = FK_OR;
            default: f = FK_AND;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Purely combinational decode of one instruction word plus PC into the decoded bundle,
// including illegal-encoding detection. Illegal bundles keep only pc and the illegal flag.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = PKG_XLEN,
    parameter bit ENABLE_OP = 1'b1
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output t_decoded_instr  o_decoded
);

    logic [6:0]     w_opcode;
    logic [2:0]     w_funct3;
    logic [6:0]     w_funct7;
    logic           w_shift_op;
    logic           w_shamt_bad;
    logic           w_illegal;
    t_xword         w_imm_i;
    t_xword         w_imm_u;
    t_xword         w_shamt;
    t_decoded_instr w_dec;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7   = i_instr[31:25];
    assign w_imm_i    = t_xword'($signed(i_instr[31:20]));
    assign w_imm_u    = t_xword'($signed({i_instr[31:12], 12'b0}));
    assign w_shift_op = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Shift-immediates: only bit 30 may be set above the shamt field.
    if (XLEN == 64) begin : g_rv64
        assign w_shamt     = t_xword'(i_instr[25:20]);
        assign w_shamt_bad = i_instr[31] | (|i_instr[29:26]);
    end else begin : g_rv32
        assign w_shamt     = t_xword'(i_instr[24:20]);
        assign w_shamt_bad = i_instr[31] | (|i_instr[29:25]);
    end

    always_comb begin
        w_dec     = '0;
        w_dec.pc  = t_xword'(i_pc);
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_dec.kind = OK_OP_IMM;
                w_dec.rd   = i_instr[11:7];
                w_dec.rs1  = i_instr[19:15];
                w_dec.func = alu_func(w_funct3, (w_funct3 == 3'b101) & i_instr[30]);
                if (w_shift_op) begin
                    w_dec.imm = w_shamt;
                    w_illegal = w_shamt_bad;
                end else begin
                    w_dec.imm = w_imm_i;
                end
            end
            OPC_OP: begin
                w_dec.kind = OK_OP;
                w_dec.rd   = i_instr[11:7];
                w_dec.rs1  = i_instr[19:15];
                w_dec.rs2  = i_instr[24:20];
                w_dec.func = alu_func(w_funct3, w_funct7 == F7_ALT);
                w_illegal  = !ENABLE_OP
                          || !((w_funct7 == F7_BASE) || (w_funct7 == F7_ALT))
                          || ((w_funct7 == F7_ALT) && (w_funct3 != 3'b000) && (w_funct3 != 3'b101));
            end
            OPC_LUI: begin
                w_dec.kind = OK_LUI;
                w_dec.rd   = i_instr[11:7];
                w_dec.imm  = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.kind = OK_AUIPC;
                w_dec.rd   = i_instr[11:7];
                w_dec.imm  = w_imm_u;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        o_decoded = w_dec;
        if (w_illegal) begin
            o_decoded         = '0;
            o_decoded.kind    = OK_ILLEGAL;
            o_decoded.pc      = t_xword'(i_pc);
            o_decoded.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: combinational decode feeding an output register plus one skid
// register, with a registered in_ready and a flush that empties both entries.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = PKG_XLEN,
    parameter bit ENABLE_OP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output t_decoded_instr  out_decoded
);

    t_decoded_instr w_dec;
    logic           w_accept;
    logic           w_drain;

    t_decoded_instr r_out;
    t_decoded_instr r_skid;
    logic           r_out_valid;
    logic           r_skid_valid;
    logic           r_in_ready;

    decode_logic #(
        .XLEN      (XLEN),
        .ENABLE_OP (ENABLE_OP)
    ) u_decode (
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .o_decoded (w_dec)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // in_ready tracks "skid empty" one edge late, so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid) begin
            if (w_drain) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (w_accept) begin
            if (!r_out_valid || out_ready) begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_decoded = r_out;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised successor to the combinational RV decoder. It sits between fetch and execute and accepts one instruction word plus PC per valid/ready handshake. It decodes OP_IMM, OP (reg-reg), LUI and AUIPC into the shared decoded-instruction bundle and flags illegal encodings. A 2-entry skid buffer keeps in_ready a registered signal, and a flush input discards in-flight work on redirect.

Parameters:
XLEN, 32, datapath width (32 or 64); sets immediate sign-extension width and shamt width (5 bits at 32, 6 bits at 64).
ENABLE_OP, 1, when 0 the OP opcode decodes as illegal (area-reduced build).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept; registered
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
flush  in  1  discard all buffered/output entries this cycle
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_decoded  out  t_decoded_instr  kind, func, rd, rs1, rs2, immediate (XLEN), pc, illegal

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid_valid=0, in_ready=1 at the first edge after release; out_decoded=0.
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- Latency: an accepted instruction appears on out_decoded with out_valid=1 exactly one cycle later if the output register is empty or draining.
- Storage: output register plus one skid register. in_ready = !skid_valid, registered.
  - Accept while the output is full and not draining: the new entry goes to the skid register.
  - Output drain with skid_valid: the skid entry moves to the output register the same edge.
  - Simultaneous accept and drain with skid empty: the output register is loaded directly.
- Order is strictly preserved. Nothing is dropped and nothing is duplicated.
- flush=1 at an edge: out_valid=0 and skid_valid=0. Any in_valid presented that cycle is dropped. in_ready=1 the next cycle. flush has priority over all other events.
- Decode, combinational ahead of the register:
  - OP_IMM funct3:
    - ADD/SLT/SLTU/AND/OR/XOR: immediate = sign-extend instr[31:20] to XLEN.
    - SLL/SRL/SRA: immediate = zero-extended shamt (instr[24:20] at 32, instr[25:20] at 64).
    - SRA is selected by instr[30].
  - OP: func from funct3 plus funct7.
    - funct7=0x20 gives SUB (funct3 000) or SRA (funct3 101).
    - funct7=0x00 gives the base op.
    - immediate=0. rs2=instr[24:20].
  - LUI/AUIPC: immediate = sign-extend {instr[31:12], 12'b0}. LUI has rs1=0.
  - illegal=1 on any of:
    - unsupported opcode
    - OP with funct7 not in {0x00, 0x20}
    - OP with funct7=0x20 on funct3 other than 000/101
    - OP when ENABLE_OP=0
    - XLEN=32 shift-immediate with instr[25]=1
    - shift-immediate with nonzero funct7 bits other than bit 30
  - On illegal: kind=OK_ILLEGAL, func=0, immediate=0, pc retained. The bundle still flows through the handshake.
- No X on out_decoded when out_valid=0; fields hold their last value.

Decomposition:
- Types package gains:
  - t_opcode values OP, LUI, AUIPC
  - kinds OK_OP, OK_LUI, OK_AUIPC, OK_ILLEGAL
  - FK_SUB
  - funct7 constants F7_BASE=0x00, F7_ALT=0x20
  - a t_decoded_instr with rs2, pc, illegal
- All of the above are parametrised-width-neutral where possible. immediate and pc use an XLEN-width typedef in the package.
- Sub-module decode_logic: purely combinational instr/pc to bundle. decode_stage instantiates it and adds the skid buffer and handshake.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), out_ready=1 -> one cycle later: OK_OP_IMM, FK_ADD, rd=1, rs1=2, imm=0xFFFFFFFF, illegal=0.
- SRAI x3,x4,5 (0x40525193) then SUB x5,x6,x7 (0x407302B3) back-to-back -> FK_SRA imm=5, then OK_OP FK_SUB rd=5 rs1=6 rs2=7. One bundle per cycle, in_ready stays 1.
- LUI x1,0x12345 (0x123450B7) issued with out_ready=0 for 3 cycles while 3 instructions are offered:
  - first two are accepted, and in_ready=0 from the cycle after the second accept;
  - the third is held by fetch;
  - after out_ready=1, all three emerge in order, and LUI has imm=0x12345000.
- Illegal encodings 0x0000007F and OP with funct7=0x01 (0x02000033) -> OK_ILLEGAL, illegal=1, pc passed through.
- flush asserted with both registers full -> next cycle out_valid=0, in_ready=1, and neither flushed instruction appears later.
- rst_n pulled low mid-stall (async, between edges) -> out_valid=0 immediately. After release, ADDI decodes correctly with no stale output.
